// File: rtl/dcache_pkg.sv
// Types and constants shared by the data cache controller, the data array and the memory interface.
package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } memif_state_t;

   localparam int DC_BLOCKWORDS  = 4;
   localparam int DC_WORD_OFF_W  = $clog2(DC_BLOCKWORDS);

endpackage

// File: rtl/dcache_beat_counter.sv
// Word counter for line-fill beats: clears, increments, and flags the final word of the line.
module dcache_beat_counter
   import dcache_pkg::*;
#(
   parameter int W = DC_WORD_OFF_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         last
);

   logic [W-1:0] count_reg;

   // Line length is a power of two, so the natural wrap returns the counter to 0 after the last beat.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count_reg <= '0;
      end else if (inc) begin
         count_reg <= count_reg + W'(1);
      end
   end

   assign count = count_reg;
   assign last  = &count_reg;

endmodule

// File: rtl/data_cache_mem_interface.sv
// Memory-side stage of the data cache: runs line fills and write-throughs over a req/ack bus
// and streams fill words into the cache data array.
module data_cache_mem_interface
   import dcache_pkg::*;
#(
   parameter int BLOCKWORDS = DC_BLOCKWORDS,
   parameter int AW         = 32,
   parameter int DW         = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          fill_req,
   input  logic                          wr_req,
   input  logic [AW-1:0]                 req_addr,
   input  logic [DW-1:0]                 req_wdata,
   output logic                          busy,
   output logic                          done,
   output logic                          fill_we,
   output logic [$clog2(BLOCKWORDS)-1:0] fill_idx,
   output logic [DW-1:0]                 fill_data,
   output logic                          mem_req,
   output logic                          mem_we,
   output logic [AW-1:0]                 mem_addr,
   output logic [DW-1:0]                 mem_wdata,
   input  logic [DW-1:0]                 mem_rdata,
   input  logic                          mem_ack
);

   localparam int IW         = $clog2(BLOCKWORDS);
   localparam int BYTE_OFF_W = $clog2(DW / 8);
   localparam int LINE_OFF_W = IW + BYTE_OFF_W;

   memif_state_t  state_reg, state_next;
   logic [AW-1:0] addr_reg;
   logic [DW-1:0] wdata_reg;
   logic [AW-1:0] line_mask, word_mask;
   logic [IW-1:0] beat;
   logic          last_beat;
   logic          beat_inc;

   // Alignment masks: line_mask clears the line offset, word_mask only the byte offset.
   generate
      for (genvar gi = 0; gi < AW; gi++) begin : g_mask
         assign line_mask[gi] = (gi >= LINE_OFF_W);
         assign word_mask[gi] = (gi >= BYTE_OFF_W);
      end
   endgenerate

   assign beat_inc = (state_reg == FILL) && mem_ack;

   dcache_beat_counter #(
      .W (IW)
   ) u_beat_counter (
      .clk   (clk),
      .reset (reset),
      .clear (state_reg != FILL),
      .inc   (beat_inc),
      .count (beat),
      .last  (last_beat)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (fill_req) begin
               state_next = FILL;
            end else if (wr_req) begin
               state_next = WRITE;
            end
         end
         FILL: begin
            if (mem_ack && last_beat) begin
               state_next = DONE;
            end
         end
         WRITE: begin
            if (mem_ack) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The address is stored pre-aligned for the chosen operation, so the beat logic only adds offsets.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         addr_reg  <= '0;
         wdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && state_next != IDLE) begin
            addr_reg  <= fill_req ? (req_addr & line_mask) : (req_addr & word_mask);
            wdata_reg <= req_wdata;
         end
      end
   end

   assign busy      = (state_reg != IDLE);
   assign done      = (state_reg == DONE);
   assign mem_req   = (state_reg == FILL) || (state_reg == WRITE);
   assign mem_we    = (state_reg == WRITE);
   assign mem_addr  = (state_reg == FILL) ? addr_reg + (AW'(beat) << BYTE_OFF_W) : addr_reg;
   assign mem_wdata = wdata_reg;
   assign fill_we   = beat_inc;
   assign fill_idx  = beat;
   assign fill_data = mem_rdata;

endmodule
